// File: rtl/series_iter_stage.sv
// Iterative exp-series evaluator: sum = 1 + x + x^2/2! + ... + x^n/n!, Q16.16, one term per clock.
// Define SERIES_SAT_EN to saturate the running sum on overflow instead of wrapping.
module series_iter_stage #(
  parameter int MAX_TERMS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_x,
  input  logic [4:0]  in_n_terms,
  output logic [31:0] out_x,
  output logic [31:0] out_num,
  output logic [31:0] out_sum,
  output logic        out_overflow,
  output logic        out_valid,
  input  logic        out_ready
);

  // state  | meaning
  // IDLE   | waiting for in_valid, in_ready=1
  // RUN    | one recurrence step per edge, k = 1..n
  // DONE   | result held, out_valid=1 until out_ready
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [4:0] N_MAX = 5'(MAX_TERMS);

  logic [1:0]         state;
  logic signed [31:0] x_q;
  logic signed [31:0] num_q;
  logic signed [31:0] sum_q;
  logic [4:0]         k_q;
  logic [4:0]         n_q;
  logic               ovf_q;

  logic [4:0]         n_clamp;
  logic [16:0]        recip;
  logic signed [63:0] num_w, x_w, prod_p, p_shift;
  logic signed [48:0] p_w, r_w, prod_t, t_shift;
  logic signed [31:0] p_val, term, sum_raw, sum_next;
  logic               ovf_p, ovf_t, ovf_s;

  assign n_clamp = (in_n_terms > N_MAX) ? N_MAX : in_n_terms;

  // round(65536/k)
  always_comb begin
    recip = 17'd0;
    case (k_q)
      5'd1:  recip = 17'd65536;
      5'd2:  recip = 17'd32768;
      5'd3:  recip = 17'd21845;
      5'd4:  recip = 17'd16384;
      5'd5:  recip = 17'd13107;
      5'd6:  recip = 17'd10923;
      5'd7:  recip = 17'd9362;
      5'd8:  recip = 17'd8192;
      5'd9:  recip = 17'd7282;
      5'd10: recip = 17'd6554;
      5'd11: recip = 17'd5958;
      5'd12: recip = 17'd5461;
      5'd13: recip = 17'd5041;
      5'd14: recip = 17'd4681;
      5'd15: recip = 17'd4369;
      5'd16: recip = 17'd4096;
      5'd17: recip = 17'd3855;
      5'd18: recip = 17'd3641;
      5'd19: recip = 17'd3449;
      5'd20: recip = 17'd3277;
      5'd21: recip = 17'd3121;
      5'd22: recip = 17'd2979;
      5'd23: recip = 17'd2849;
      5'd24: recip = 17'd2731;
      5'd25: recip = 17'd2621;
      5'd26: recip = 17'd2521;
      5'd27: recip = 17'd2427;
      5'd28: recip = 17'd2341;
      5'd29: recip = 17'd2260;
      5'd30: recip = 17'd2185;
      5'd31: recip = 17'd2114;
      default: recip = 17'd0;
    endcase
  end

  assign num_w   = {{32{num_q[31]}}, num_q};
  assign x_w     = {{32{x_q[31]}}, x_q};
  assign prod_p  = num_w * x_w;
  assign p_shift = prod_p >>> 16;
  assign p_val   = p_shift[31:0];
  // Truncation is lossless only if everything above bit 31 copies the sign.
  assign ovf_p   = !((&p_shift[63:31]) || !(|p_shift[63:31]));

  assign p_w     = {{17{p_val[31]}}, p_val};
  assign r_w     = {32'd0, recip};
  assign prod_t  = p_w * r_w;
  assign t_shift = prod_t >>> 16;
  assign term    = t_shift[31:0];
  assign ovf_t   = !((&t_shift[48:31]) || !(|t_shift[48:31]));

  assign sum_raw = sum_q + term;
  assign ovf_s   = (sum_q[31] == term[31]) && (sum_raw[31] != sum_q[31]);

`ifdef SERIES_SAT_EN
  assign sum_next = ovf_s ? (sum_q[31] ? 32'sh80000000 : 32'sh7FFFFFFF) : sum_raw;
`else
  assign sum_next = sum_raw;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      x_q   <= '0;
      num_q <= '0;
      sum_q <= '0;
      k_q   <= '0;
      n_q   <= '0;
      ovf_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            x_q   <= in_x;
            num_q <= 32'sh00010000;
            sum_q <= 32'sh00010000;
            k_q   <= 5'd1;
            n_q   <= n_clamp;
            ovf_q <= 1'b0;
            state <= (n_clamp == 5'd0) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          num_q <= term;
          sum_q <= sum_next;
          k_q   <= k_q + 5'd1;
          ovf_q <= ovf_q | ovf_p | ovf_t | ovf_s;
          if (k_q == n_q) state <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign in_ready     = (state == S_IDLE);
  assign out_valid    = (state == S_DONE);
  assign out_x        = x_q;
  assign out_num      = num_q;
  assign out_sum      = sum_q;
  assign out_overflow = ovf_q;

endmodule
